// File: rtl/ir_nec_pkg.sv
// ir_nec_pkg: shared states, error codes, NEC nominal timings and cycle conversion
package ir_nec_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEAD_MARK,
        S_LEAD_SPACE,
        S_BIT_MARK,
        S_BIT_SPACE,
        S_STOP_MARK,
        S_REP_STOP,
        S_CHECK,
        S_REP_CHECK
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMING  = 2'd1;
    localparam logic [1:0] ERR_INV     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam int T_LEAD_MARK_US  = 9000;
    localparam int T_LEAD_SPACE_US = 4500;
    localparam int T_REP_SPACE_US  = 2250;
    localparam int T_BIT_MARK_US   = 560;
    localparam int T_ZERO_US       = 560;
    localparam int T_ONE_US        = 1690;
    localparam int T_STOP_US       = 560;

    // pct is the scaled percentage, e.g. 100-TOL for the window floor
    function automatic int us_to_cyc(input int us, input int clk_hz, input int pct);
        return int'(longint'(us) * longint'(clk_hz) * longint'(pct) / 64'sd100_000_000);
    endfunction

endpackage

// File: rtl/ir_nec_rx_param_if.sv
// ir_nec_rx_param_if: IR input line and decoded-frame outputs of the receiver
interface ir_nec_rx_param_if;
    logic        infrared_in;
    logic [15:0] addr;
    logic [7:0]  cmd;
    logic        data_valid;
    logic        repeat_en;
    logic        frame_err;
    logic [1:0]  err_code;
    logic        busy;

    modport master (
        input  infrared_in,
        output addr, cmd, data_valid, repeat_en, frame_err, err_code, busy
    );

    modport slave (
        output infrared_in,
        input  addr, cmd, data_valid, repeat_en, frame_err, err_code, busy
    );
endinterface

// File: rtl/ir_sync_filter.sv
// ir_sync_filter: synchronise the raw IR line, reject short glitches, report mark level
module ir_sync_filter #(
    parameter int GLITCH_CYC = 8,
    parameter int ACTIVE_LOW = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic mark
);
    localparam logic IDLE_LVL = ACTIVE_LOW != 0;
    localparam int   GW       = $clog2(GLITCH_CYC + 1);

    logic [1:0]    sync_q;
    logic          lvl;
    logic [GW-1:0] cnt;

    // two-flop synchroniser, then accept a new level only after GLITCH_CYC differing samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {2{IDLE_LVL}};
            lvl    <= IDLE_LVL;
            cnt    <= '0;
        end else begin
            sync_q <= {sync_q[0], raw};
            if (sync_q[1] == lvl) begin
                cnt <= '0;
            end else if (cnt == GW'(GLITCH_CYC - 1)) begin
                lvl <= sync_q[1];
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign mark = lvl ^ IDLE_LVL;
endmodule

// File: rtl/ir_nec_rx_param.sv
// ir_nec_rx_param: NEC frame/repeat decoder with tolerance windows, checks and timeouts
module ir_nec_rx_param
    import ir_nec_pkg::*;
#(
    parameter int CLK_HZ        = 50_000_000,
    parameter int TOL_PCT       = 20,
    parameter int EXT_ADDR      = 0,
    parameter int ACTIVE_LOW    = 1,
    parameter int GLITCH_CYC    = 8,
    parameter int REPEAT_WIN_MS = 120
) (
    input logic               sys_clk,
    input logic               sys_rst,
    ir_nec_rx_param_if.master bus
);
    localparam int LO = 100 - TOL_PCT;
    localparam int HI = 100 + TOL_PCT;
    localparam int LM_LO = us_to_cyc(T_LEAD_MARK_US, CLK_HZ, LO);
    localparam int LM_HI = us_to_cyc(T_LEAD_MARK_US, CLK_HZ, HI);
    localparam int FS_LO = us_to_cyc(T_LEAD_SPACE_US, CLK_HZ, LO);
    localparam int FS_HI = us_to_cyc(T_LEAD_SPACE_US, CLK_HZ, HI);
    localparam int RS_LO = us_to_cyc(T_REP_SPACE_US, CLK_HZ, LO);
    localparam int RS_HI = us_to_cyc(T_REP_SPACE_US, CLK_HZ, HI);
    localparam int BM_LO = us_to_cyc(T_BIT_MARK_US, CLK_HZ, LO);
    localparam int BM_HI = us_to_cyc(T_BIT_MARK_US, CLK_HZ, HI);
    localparam int S0_LO = us_to_cyc(T_ZERO_US, CLK_HZ, LO);
    localparam int S0_HI = us_to_cyc(T_ZERO_US, CLK_HZ, HI);
    localparam int S1_LO = us_to_cyc(T_ONE_US, CLK_HZ, LO);
    localparam int S1_HI = us_to_cyc(T_ONE_US, CLK_HZ, HI);
    localparam int SM_LO = us_to_cyc(T_STOP_US, CLK_HZ, LO);
    localparam int SM_HI = us_to_cyc(T_STOP_US, CLK_HZ, HI);
    // one spare count so a saturated counter is always beyond the longest window
    localparam int DW     = $clog2(LM_HI + 2);
    localparam int RW_CYC = int'(longint'(REPEAT_WIN_MS) * longint'(CLK_HZ) / 64'sd1000);
    localparam int RW_W   = $clog2(RW_CYC + 1);

    state_t          state, state_n;
    logic            mark, mark_d, flip, frame_ok;
    logic            fr_end, rp_end, shift, bit_one, clr_idx;
    logic [1:0]      err_n;
    logic [DW-1:0]   dur;
    logic [4:0]      idx;
    logic [31:0]     sr;
    logic [RW_W-1:0] rep_tmr;

    function automatic logic inw(input logic [DW-1:0] d, input int lo, input int hi);
        return int'(d) >= lo && int'(d) <= hi;
    endfunction

    ir_sync_filter #(
        .GLITCH_CYC(GLITCH_CYC),
        .ACTIVE_LOW(ACTIVE_LOW)
    ) u_filt (
        .clk (sys_clk),
        .rst (sys_rst),
        .raw (bus.infrared_in),
        .mark(mark)
    );

    assign flip     = mark ^ mark_d;
    assign frame_ok = (sr[31:24] == ~sr[23:16]) && (EXT_ADDR != 0 || sr[15:8] == ~sr[7:0]);
    assign bus.busy = state != S_IDLE;

    // FSM state register
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) state <= S_IDLE;
        else         state <= state_n;
    end

    // each edge ends the current segment and is judged against that segment's window
    always_comb begin
        state_n = state;
        err_n   = ERR_NONE;
        fr_end  = 1'b0;
        rp_end  = 1'b0;
        shift   = 1'b0;
        bit_one = 1'b0;
        clr_idx = 1'b0;
        case (state)
            S_IDLE: if (flip && mark) state_n = S_LEAD_MARK;
            S_LEAD_MARK:
                if (flip) begin
                    state_n = S_LEAD_SPACE;
                    err_n   = inw(dur, LM_LO, LM_HI) ? ERR_NONE : ERR_TIMING;
                end else if (int'(dur) > LM_HI) begin
                    err_n = ERR_TIMEOUT;
                end
            S_LEAD_SPACE:
                if (flip) begin
                    clr_idx = 1'b1;
                    state_n = inw(dur, FS_LO, FS_HI) ? S_BIT_MARK : S_REP_STOP;
                    err_n   = (inw(dur, FS_LO, FS_HI) || inw(dur, RS_LO, RS_HI)) ? ERR_NONE : ERR_TIMING;
                end else if (int'(dur) > FS_HI) begin
                    err_n = ERR_TIMEOUT;
                end
            S_BIT_MARK:
                if (flip) begin
                    state_n = S_BIT_SPACE;
                    err_n   = inw(dur, BM_LO, BM_HI) ? ERR_NONE : ERR_TIMING;
                end else if (int'(dur) > BM_HI) begin
                    err_n = ERR_TIMEOUT;
                end
            S_BIT_SPACE:
                if (flip) begin
                    bit_one = inw(dur, S1_LO, S1_HI);
                    shift   = bit_one || inw(dur, S0_LO, S0_HI);
                    state_n = idx == 5'd31 ? S_STOP_MARK : S_BIT_MARK;
                    err_n   = shift ? ERR_NONE : ERR_TIMING;
                end else if (int'(dur) > S1_HI) begin
                    err_n = ERR_TIMEOUT;
                end
            S_STOP_MARK, S_REP_STOP:
                if (flip) begin
                    fr_end  = state == S_STOP_MARK;
                    rp_end  = state == S_REP_STOP;
                    state_n = state == S_STOP_MARK ? S_CHECK : S_REP_CHECK;
                    err_n   = inw(dur, SM_LO, SM_HI) ? ERR_NONE : ERR_TIMING;
                end else if (int'(dur) > SM_HI) begin
                    err_n = ERR_TIMEOUT;
                end
            default: state_n = S_IDLE;
        endcase
        if (err_n != ERR_NONE) begin
            state_n = S_IDLE;
            fr_end  = 1'b0;
            rp_end  = 1'b0;
            shift   = 1'b0;
        end
    end

    // duration counter, bit shifter, repeat window and registered result/pulse outputs
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            mark_d         <= 1'b0;
            dur            <= '0;
            idx            <= '0;
            sr             <= '0;
            rep_tmr        <= '0;
            bus.addr       <= '0;
            bus.cmd        <= '0;
            bus.data_valid <= 1'b0;
            bus.repeat_en  <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.err_code   <= ERR_NONE;
        end else begin
            mark_d         <= mark;
            dur            <= flip ? '0 : (&dur ? dur : dur + 1'b1);
            idx            <= clr_idx ? 5'd0 : (shift ? idx + 1'b1 : idx);
            sr             <= shift ? {bit_one, sr[31:1]} : sr;
            rep_tmr        <= rep_tmr != '0 ? rep_tmr - 1'b1 : rep_tmr;
            bus.data_valid <= 1'b0;
            bus.repeat_en  <= 1'b0;
            bus.frame_err  <= 1'b0;
            if (err_n != ERR_NONE) begin
                bus.frame_err <= 1'b1;
                bus.err_code  <= err_n;
            end else if (fr_end && frame_ok) begin
                bus.addr       <= EXT_ADDR != 0 ? sr[15:0] : {8'h00, sr[7:0]};
                bus.cmd        <= sr[23:16];
                bus.data_valid <= 1'b1;
                bus.err_code   <= ERR_NONE;
                rep_tmr        <= RW_W'(RW_CYC);
            end else if (fr_end) begin
                bus.frame_err <= 1'b1;
                bus.err_code  <= ERR_INV;
            end else if (rp_end && rep_tmr != '0) begin
                bus.repeat_en <= 1'b1;
                rep_tmr       <= RW_W'(RW_CYC);
            end
        end
    end
endmodule

// File: doc/ir_nec_rx_param.md
Name: ir_nec_rx_param

Overview:
Parametrised NEC infrared receiver; successor to infrared_rcv. Synchronises and glitch-filters the raw IR demodulator output, measures mark/space durations against tolerance windows derived from CLK_HZ, and decodes 32-bit NEC frames and repeat codes. Supports standard (8-bit address plus inverse) and extended (16-bit address) modes, integrity checks, timeouts and error reporting. Sits between the IR receiver pin and the command-dispatch logic.

Parameters:
CLK_HZ, 50_000_000, sys_clk frequency; all timing windows are derived from it in cycles.
TOL_PCT, 20, +/- tolerance on every nominal duration, in percent.
EXT_ADDR, 0, 0: address byte must equal ~inverse byte; 1: 16-bit address, no address check.
ACTIVE_LOW, 1, 1: mark = infrared_in low; 0: mark = infrared_in high.
GLITCH_CYC, 8, number of consecutive stable samples required before a level change is accepted.
REPEAT_WIN_MS, 120, maximum time from the end of the last valid frame/repeat within which a repeat code is accepted.

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  asynchronous reset, active-high
infrared_in  in  1  raw demodulated IR line, asynchronous
addr  out  16  decoded address; standard mode {8'h00, byte0}; extended mode {byte1, byte0}
cmd  out  8  decoded command byte
data_valid  out  1  one-cycle pulse: new frame decoded
repeat_en  out  1  one-cycle pulse: accepted repeat code
frame_err  out  1  one-cycle pulse: frame aborted
err_code  out  2  0 none, 1 timing out of window, 2 inverse check failed, 3 timeout; held until the next frame_err or data_valid
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters cleared, repeat-window timer expired. Reset asserted mid-frame aborts the frame silently (no frame_err).
- Input path: two-flop synchroniser, then glitch filter (GLITCH_CYC); then polarity normalisation to mark/space. Fixed input latency of 2+GLITCH_CYC cycles.
- Nominal durations: lead mark 9 ms; lead space 4.5 ms (frame) or 2.25 ms (repeat); bit mark 560 us; bit space 560 us (0) or 1690 us (1); stop mark 560 us.
- Window for each duration: [nom*(100-TOL_PCT)/100, nom*(100+TOL_PCT)/100] cycles.
- Duration counter: width is clog2 of the largest window maximum. Cleared on every accepted edge. Saturates; never wraps.
- FSM states and transitions:
  - IDLE: mark start -> LEAD_MARK.
  - LEAD_MARK: in-window end -> LEAD_SPACE.
  - LEAD_SPACE: space in frame window -> BIT_MARK with bit index 0; space in repeat window -> REP_STOP.
  - BIT_MARK: in-window end -> BIT_SPACE.
  - BIT_SPACE: classifies the bit and shifts it in LSB-first; index 31 -> STOP_MARK, otherwise -> BIT_MARK.
  - STOP_MARK / REP_STOP: in-window stop mark end -> CHECK / REP_CHECK.
  - CHECK and REP_CHECK last one cycle, then -> IDLE.
- Any out-of-window edge: frame_err, err_code=1, -> IDLE.
- Any segment exceeding its window maximum without an edge: frame_err, err_code=3, -> IDLE immediately. The line must return to space before a new frame is accepted.
- CHECK:
  - byte3 != ~byte2, or (EXT_ADDR=0 and byte1 != ~byte0): frame_err, err_code=2; addr/cmd unchanged.
  - Otherwise addr/cmd are updated and data_valid pulses in the same cycle, one cycle after the stop-mark end is detected. Restarts the repeat window.
- REP_CHECK: repeat window open -> repeat_en pulse, window restarted, addr/cmd unchanged. Window expired -> repeat is ignored silently (no error).
- addr/cmd hold their value until the next valid frame.
- data_valid, repeat_en and frame_err are mutually exclusive, one cycle each.
- A mark start during IDLE restarts decoding; a mark start in other states is judged as an edge per the rules above.

Decomposition:
- Package ir_nec_pkg: FSM state enum, err_code constants, nominal durations in microseconds, and a function converting us -> cycles with tolerance.
- Sub-module ir_sync_filter (synchroniser, glitch filter, polarity); the FSM, counters and shift register stay in the top.

Test Plan:
- Sim with CLK_HZ=1_000_000. Frame addr 0x4D cmd 0x80 -> one data_valid; addr=0x004D, cmd=0x80, err_code=0, busy low afterwards.
- Same frame, then repeat code 40 ms after the stop mark -> repeat_en pulses once, addr/cmd unchanged. Repeat 200 ms after -> no pulse, no error.
- Frame with cmd_inv=0x7E -> frame_err, err_code=2, addr/cmd keep the previous values.
- EXT_ADDR=1, address bytes 0x34,0x12, cmd 0x10 -> addr=0x1234, data_valid.
- Bit space 1.2 ms -> frame_err, err_code=1. Line held low 15 ms -> err_code=3.
- 3-cycle glitches inside spaces -> ignored, frame decodes correctly. sys_rst pulsed mid-frame -> all outputs 0, no frame_err, next frame decodes.
